wtc_count_ctrl: RTL and testbench

Switch-driven 8-bit count controller for the GoBoard. It debounces the four raw push-buttons and turns presses into increment, decrement, clear and run-toggle events. It maintains the count value that the two downstream `wtc_7seg` instances display, with the high nibble on digit 1 and the low nibble on digit 2. It also drives a status flag for an LED.

---
 rtl/wtc_count_pkg.sv | 16 +
 rtl/wtc_debounce.sv | 49 ++++
 rtl/wtc_count_ctrl.sv | 112 +++++++++++
 tb/tb_wtc_count_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wtc_count_pkg.sv
// Shared constants and switch-role enumeration for the GoBoard count controller.
package wtc_count_pkg;

    localparam int WTC_COUNT_WIDTH    = 8;
    localparam int WTC_DEBOUNCE_LIMIT = 250000;    // 10 ms at 25 MHz
    localparam int WTC_TICK_LIMIT     = 25000000;  // 1 Hz at 25 MHz

    // Bit positions of each button in the press/stable vectors.
    typedef enum logic [1:0] {
        INC = 2'd0,
        DEC = 2'd1,
        CLR = 2'd2,
        RUN = 2'd3
    } sw_role_e;

endpackage

// File: rtl/wtc_debounce.sv
// One-bit switch filter: the stable state flips after DEBOUNCE_LIMIT consecutive
// differing samples; o_Press pulses for one cycle on each stable rising edge.
module wtc_debounce
    import wtc_count_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = WTC_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Stable,
    output logic o_Press
);

    localparam int             CW   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (i_Switch != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    assign o_Stable = stable_q;
    assign o_Press  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/wtc_count_ctrl.sv
// Debounced button-driven 8-bit counter with optional 1 Hz auto-run mode.
// Auto-run (Switch 4, tick counter, o_Run) exists only with WTC_COUNT_AUTORUN_EN defined.
module wtc_count_ctrl
    import wtc_count_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = WTC_DEBOUNCE_LIMIT,
    parameter int TICK_LIMIT     = WTC_TICK_LIMIT,
    parameter int COUNT_WIDTH    = WTC_COUNT_WIDTH
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Switch_1,
    input  logic                   i_Switch_2,
    input  logic                   i_Switch_3,
    input  logic                   i_Switch_4,
    output logic [COUNT_WIDTH-1:0] o_Count,
    output logic                   o_Count_Valid,
    output logic                   o_Run
);

    logic [2:0]             raw;
    logic [3:0]             press;
    logic [3:0]             unused_stable;
    logic                   tick;
    logic                   run_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   valid_q, valid_d;

    assign raw = {i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < 3; g++) begin : g_db
        wtc_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db (
            .i_Clk    (i_Clk),
            .i_Reset  (i_Reset),
            .i_Switch (raw[g]),
            .o_Stable (unused_stable[g]),
            .o_Press  (press[g])
        );
    end

`ifdef WTC_COUNT_AUTORUN_EN
    localparam int             TW        = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_LIMIT - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic          run_d;

    wtc_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_run (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Switch_4),
        .o_Stable (unused_stable[RUN]),
        .o_Press  (press[RUN])
    );

    assign tick = run_q && (tick_q == TICK_LAST);

    // Held at zero outside run mode so the first tick lands a full period after entry.
    always_comb begin
        tick_d = tick_q + 1'b1;
        if (!run_q || press[CLR] || tick) begin
            tick_d = '0;
        end
        run_d = run_q ^ press[RUN];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            tick_q <= '0;
            run_q  <= 1'b0;
        end else begin
            tick_q <= tick_d;
            run_q  <= run_d;
        end
    end
`else
    logic unused_cfg;

    assign press[RUN]         = 1'b0;
    assign unused_stable[RUN] = 1'b0;
    assign tick               = 1'b0;
    assign run_q              = 1'b0;
    assign unused_cfg         = i_Switch_4 | (TICK_LIMIT < 1);
`endif

    // Clear wins outright; otherwise all deltas sum and wrap modulo 2^COUNT_WIDTH.
    always_comb begin
        count_d = count_q;
        if (press[CLR]) begin
            count_d = '0;
        end else begin
            count_d = count_q + COUNT_WIDTH'(press[INC]) + COUNT_WIDTH'(tick)
                      - COUNT_WIDTH'(press[DEC]);
        end
        valid_d = (count_d != count_q);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign o_Count       = count_q;
    assign o_Count_Valid = valid_q;
    assign o_Run         = run_q;

endmodule

// File: tb/tb_wtc_count_ctrl.sv
// Scoreboard bench for wtc_count_ctrl with DEBOUNCE_LIMIT=4, TICK_LIMIT=10.
module tb_wtc_count_ctrl;

    localparam int DL = 4;
    localparam int TL = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
    logic [7:0] count;
    logic       valid;
    logic       run;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model = 8'h00;
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    wtc_count_ctrl #(
        .DEBOUNCE_LIMIT (DL),
        .TICK_LIMIT     (TL),
        .COUNT_WIDTH    (8)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Switch_1    (sw1),
        .i_Switch_2    (sw2),
        .i_Switch_3    (sw3),
        .i_Switch_4    (sw4),
        .o_Count       (count),
        .o_Count_Valid (valid),
        .o_Run         (run)
    );

    // Every valid pulse must match the next expected count value.
    always @(negedge clk) begin
        if (!rst && valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid got count=%h want no pulse", count);
            end else begin
                mon_exp = exp_q.pop_front();
                if (count !== mon_exp) begin
                    failures++;
                    $display("FAIL scoreboard_count got=%h want=%h", count, mon_exp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_if_changed(input logic [7:0] nv);
        if (nv != model) exp_q.push_back(nv);
        model = nv;
    endtask

    // Presses switch mask {sw4,sw3,sw2,sw1} long enough to register, then releases.
    task automatic do_press(input logic [3:0] m);
        logic [7:0] nv;
        if (m[2]) nv = 8'h00;
        else      nv = model + {7'd0, m[0]} - {7'd0, m[1]};
        push_if_changed(nv);
        {sw4, sw3, sw2, sw1} = m;
        step(DL + 1);
        {sw4, sw3, sw2, sw1} = 4'b0000;
        step(DL + 2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h want=00", count); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (run !== 1'b0)    begin failures++; $display("FAIL reset_run got=%b want=0", run); end
        rst = 1'b0;
        model = 8'h00;
        exp_q.delete();
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        sw1 = 1'b1;
        step(DL - 1);
        sw1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)   begin failures++; $display("FAIL glitch_valid got=%b want=0", seen); end
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL glitch_count got=%h want=00", count); end
    endtask

    task automatic test_single_press();
        push_if_changed(model + 8'h01);
        sw1 = 1'b1;
        step(DL);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL press_early got=%h want=00", count); end
        step(1);
        checks++; if (count !== 8'h01) begin failures++; $display("FAIL press_latency got=%h want=01", count); end
        checks++; if (valid !== 1'b1)  begin failures++; $display("FAIL press_valid got=%b want=1", valid); end
        step(1);
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL press_pulse_width got=%b want=0", valid); end
        step(2);
        sw1 = 1'b0;
        step(12);
        checks++; if (count !== 8'h01) begin failures++; $display("FAIL press_hold_release got=%h want=01", count); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL press_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_clear();
        do_press(4'b0100);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL clear got=%h want=00", count); end
        do_press(4'b0100);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL clear_at_zero got=%h want=00", count); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL clear_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        do_press(4'b0010);
        checks++; if (count !== 8'hFF) begin failures++; $display("FAIL wrap_down got=%h want=ff", count); end
        do_press(4'b0001);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL wrap_up got=%h want=00", count); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) do_press(4'b0001);
        checks++; if (count !== 8'h10) begin failures++; $display("FAIL reach_10 got=%h want=10", count); end
        do_press(4'b0011);
        checks++; if (count !== 8'h10) begin failures++; $display("FAIL inc_dec_cancel got=%h want=10", count); end
        do_press(4'b0101);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL inc_clr got=%h want=00", count); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL simul_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_pending();
        sw1 = 1'b1;
        step(DL - 1);
        rst = 1'b1;
        sw1 = 1'b0;
        step(1);
        rst = 1'b0;
        exp_q.delete();
        model = 8'h00;
        step(12);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h want=00", count); end
    endtask

`ifdef WTC_COUNT_AUTORUN_EN
    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(TL - 1);
            checks++; if (count !== model) begin failures++; $display("FAIL tick_early got=%h want=%h", count, model); end
            push_if_changed(model + 8'h01);
            step(1);
            checks++; if (count !== model) begin failures++; $display("FAIL tick_count got=%h want=%h", count, model); end
        end
    endtask

    task automatic test_run_mode();
        sw4 = 1'b1;
        step(DL);
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL run_early got=%b want=0", run); end
        step(1);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL run_on got=%b want=1", run); end
        sw4 = 1'b0;
        run_ticks(3);
        sw4 = 1'b1;
        step(DL + 1);
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL run_off got=%b want=0", run); end
        sw4 = 1'b0;
        step(3 * TL);
        checks++; if (count !== 8'h03) begin failures++; $display("FAIL run_stopped got=%h want=03", count); end
        sw4 = 1'b1;
        step(DL + 1);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL run_on_again got=%b want=1", run); end
        sw4 = 1'b0;
        run_ticks(4);
        checks++; if (count !== 8'h07) begin failures++; $display("FAIL run_reach_07 got=%h want=07", count); end
    endtask

    task automatic test_reset_mid_run();
        step(3);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL run_drain got=%0d want=0", exp_q.size()); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL midrun_count got=%h want=00", count); end
        checks++; if (run !== 1'b0)    begin failures++; $display("FAIL midrun_run got=%b want=0", run); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL midrun_valid got=%b want=0", valid); end
        exp_q.delete();
        model = 8'h00;
        step(2 * TL);
        checks++; if (count !== 8'h00) begin failures++; $display("FAIL midrun_stays got=%h want=00", count); end
    endtask
`else
    task automatic test_run_disabled();
        sw4 = 1'b1;
        step(2 * DL);
        sw4 = 1'b0;
        step(3 * TL);
        checks++; if (run !== 1'b0)  begin failures++; $display("FAIL run_disabled got=%b want=0", run); end
        checks++; if (count !== model) begin failures++; $display("FAIL run_disabled_count got=%h want=%h", count, model); end
    endtask
`endif

    initial begin
        step(1);
        test_reset();
        test_glitch();
        test_single_press();
        test_clear();
        test_wrap();
        test_simultaneous();
        test_reset_pending();
`ifdef WTC_COUNT_AUTORUN_EN
        test_run_mode();
        test_reset_mid_run();
`else
        test_run_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
